// File: rtl/div60x32_seq_pkg.sv
// div60x32_seq_pkg: widths, state encoding and saturation limits for the sequential divider
package div60x32_seq_pkg;
  localparam int DW = 60;
  localparam int VW = 32;
  localparam int QW = 28;
  localparam int CW = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;
  localparam logic [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};
endpackage

// File: rtl/div60x32_seq_if.sv
// div60x32_seq_if: operand/result handshake bundle for the sequential divider
interface div60x32_seq_if;
  import div60x32_seq_pkg::*;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic          out_valid;
  logic [QW-1:0] q;
  logic [VW-1:0] r;
  logic          ovf;
  logic          dz;
  logic          busy;
  modport master(output in_valid, a, b, input in_ready, out_valid, q, r, ovf, dz, busy);
  modport slave(input in_valid, a, b, output in_ready, out_valid, q, r, ovf, dz, busy);
endinterface

// File: rtl/div60x32_seq_core.sv
// div60x32_seq_core: radix-2 restoring magnitude datapath, one quotient bit per enabled clock
module div60x32_seq_core
  import div60x32_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] a_mag,
  input  logic [VW-1:0] b_mag,
  output logic [DW-1:0] qmag,
  output logic [VW-1:0] pr,
  output logic [CW-1:0] cnt,
  output logic          b_zero
);
  logic [VW-1:0] bm;
  logic [VW:0]   sh;
  logic [VW-1:0] diff;
  logic          ge;
  always_comb begin
    sh   = {pr, qmag[DW-1]};
    ge   = sh >= {1'b0, bm};
    diff = sh[VW-1:0] - bm;
  end
  assign b_zero = bm == '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pr   <= '0;
      qmag <= '0;
      bm   <= '0;
      cnt  <= '0;
    end else if (load) begin
      pr   <= '0;
      qmag <= a_mag;
      bm   <= b_mag;
      cnt  <= '0;
    end else if (en) begin
      pr   <= ge ? diff : sh[VW-1:0];
      qmag <= {qmag[DW-2:0], ge};
      cnt  <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/div60x32_seq.sv
// div60x32_seq: signed 60/32 sequential divider with saturating 28-bit quotient and truncating remainder
module div60x32_seq
  import div60x32_seq_pkg::*;
(
  input logic           clk,
  input logic           reset,
  div60x32_seq_if.slave bus
);
  state_t        state;
  logic          sa;
  logic          sb;
  logic [VW-1:0] a_lo;
  logic [DW-1:0] qmag;
  logic [VW-1:0] pr;
  logic [CW-1:0] cnt;
  logic          b_zero;
  logic          accept;
  logic          neg;
  logic          ovf_n;
  logic [DW-1:0] a_mag;
  logic [VW-1:0] b_mag;
  logic [QW-1:0] q_n;
  logic [VW-1:0] r_n;
  always_comb begin
    accept = state == IDLE && bus.in_valid;
    a_mag  = bus.a[DW-1] ? -bus.a : bus.a;
    b_mag  = bus.b[VW-1] ? -bus.b : bus.b;
    neg    = sa ^ sb;
    ovf_n  = !b_zero && (neg ? qmag > DW'(QMIN) : qmag > DW'(QMAX));
    q_n    = b_zero ? (sa ? QMIN : QMAX) : ovf_n ? (neg ? QMIN : QMAX) : neg ? -qmag[QW-1:0] : qmag[QW-1:0];
    r_n    = b_zero ? a_lo : sa ? -pr : pr;
  end
  div60x32_seq_core u_core (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .en    (state == CALC),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .qmag  (qmag),
    .pr    (pr),
    .cnt   (cnt),
    .b_zero(b_zero)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.q         <= '0;
      bus.r         <= '0;
      bus.ovf       <= 1'b0;
      bus.dz        <= 1'b0;
      bus.busy      <= 1'b0;
      sa            <= 1'b0;
      sb            <= 1'b0;
      a_lo          <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          sa           <= bus.a[DW-1];
          sb           <= bus.b[VW-1];
          a_lo         <= bus.a[VW-1:0];
          state        <= CALC;
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b1;
        end
        CALC: if (cnt == CW'(DW-1)) state <= FIX;
        FIX: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.busy      <= 1'b0;
          bus.out_valid <= 1'b1;
          bus.q         <= q_n;
          bus.r         <= r_n;
          bus.ovf       <= ovf_n;
          bus.dz        <= b_zero;
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div60x32_seq.sv
// tb_div60x32_seq: directed-vector self-checking bench for div60x32_seq
module tb_div60x32_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  div60x32_seq_if bus ();
  div60x32_seq dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic wait_out(input string nm);
    int cyc;
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, ".lat"}, cyc, 61);
  endtask
  task automatic check_res(input string nm, input longint eq, input longint er, input logic eovf, input logic edz);
    check({nm, ".q"}, longint'($signed(bus.q)), eq);
    check({nm, ".r"}, longint'($signed(bus.r)), er);
    check({nm, ".ovf"}, longint'(bus.ovf), longint'(eovf));
    check({nm, ".dz"}, longint'(bus.dz), longint'(edz));
  endtask
  task automatic run(input string nm, input longint av, input longint bv, input longint eq, input longint er,
                     input logic eovf, input logic edz);
    @(negedge clk);
    check({nm, ".rdy"}, longint'(bus.in_ready), 1);
    bus.a = av[59:0];
    bus.b = bv[31:0];
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(nm);
    check_res(nm, eq, er, eovf, edz);
    @(negedge clk);
    check({nm, ".pulse"}, longint'(bus.out_valid), 0);
  endtask
  initial begin
    bit seen;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst.rdy", longint'(bus.in_ready), 1);
    check("rst.ov", longint'(bus.out_valid), 0);
    check("rst.busy", longint'(bus.busy), 0);
    check_res("rst", 0, 0, 1'b0, 1'b0);
    run("p7", 1000000, 7, 142857, 1, 1'b0, 1'b0);
    run("n7", -1000000, 7, -142857, -1, 1'b0, 1'b0);
    run("pn7", 1000000, -7, -142857, 1, 1'b0, 1'b0);
    run("nn5", -17, -5, 3, -2, 1'b0, 1'b0);
    run("dzp", 5, 0, 134217727, 5, 1'b0, 1'b1);
    run("dzn", -5, 0, -134217728, -5, 1'b0, 1'b1);
    run("big", longint'(1) << 40, 1, 134217727, 0, 1'b1, 1'b0);
    run("qmin", -(longint'(1) << 27), 1, -134217728, 0, 1'b0, 1'b0);
    run("qmin1", -(longint'(1) << 27) - 1, 1, -134217728, 0, 1'b1, 1'b0);
    run("qmax", (longint'(1) << 27) - 1, 1, 134217727, 0, 1'b0, 1'b0);
    run("qmax1", longint'(1) << 27, 1, 134217727, 0, 1'b1, 1'b0);
    run("corner", -(longint'(1) << 59), -(longint'(1) << 31), 134217727, 0, 1'b1, 1'b0);
    run("zero", 0, 5, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    bus.a = 60'd1000000;
    bus.b = 32'd7;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.a = 60'd12;
    bus.b = 32'd5;
    check("hold.busy", longint'(bus.busy), 1);
    check("hold.rdy", longint'(bus.in_ready), 0);
    wait_out("hold");
    check_res("hold", 142857, 1, 1'b0, 1'b0);
    check("b2b.rdy", longint'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out("b2b");
    check_res("b2b", 2, 2, 1'b0, 1'b0);
    @(negedge clk);
    bus.a = 60'd1000000;
    bus.b = 32'd3;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("abort.busy", longint'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort.rdy", longint'(bus.in_ready), 1);
    check("abort.busy0", longint'(bus.busy), 0);
    check_res("abort", 0, 0, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort.noov", longint'(seen), 0);
    run("post", 100, 7, 14, 2, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
